// File: rtl/btb_update_queue_if.sv
// Upstream resolution lanes and BTB write-port signals of the BTB update queue.
// The master side belongs to the producer/BTB; the slave side belongs to the queue.
interface btb_update_queue_if #(
  parameter int N      = 3,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
);
  logic [N-1:0]                 enq_valid;
  logic [N*ADDR_W-1:0]          enq_branch_PC;
  logic [N*ADDR_W-1:0]          enq_target_PC;
  logic [$clog2(DEPTH+1)-1:0]   free_slots;
  logic                         overflow;
  logic                         resolving_valid;
  logic [ADDR_W-1:0]            resolving_branch_PC;
  logic [ADDR_W-1:0]            resolving_target_PC;

  modport master (
    output enq_valid, enq_branch_PC, enq_target_PC,
    input  free_slots, overflow, resolving_valid, resolving_branch_PC, resolving_target_PC
  );

  modport slave (
    input  enq_valid, enq_branch_PC, enq_target_PC,
    output free_slots, overflow, resolving_valid, resolving_branch_PC, resolving_target_PC
  );
endinterface

// File: rtl/btb_update_queue.sv
// Coalescing queue of resolved-branch BTB updates: up to N per cycle in,
// one per cycle out, drops on overflow instead of stalling.
module btb_update_queue #(
  parameter int N      = 3,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  btb_update_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] bpc_q [DEPTH];
  logic [ADDR_W-1:0] tgt_q [DEPTH];
  logic [ADDR_W-1:0] bpc_d [DEPTH];
  logic [ADDR_W-1:0] tgt_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q;

  logic              deq_s;
  logic              drop_s;
  logic [CW-1:0]     cap_s;
  logic [CW-1:0]     alloc_s;
  logic [ADDR_W-1:0] lane_pc_s, lane_tgt_s;
  logic              survive_s, hit_s;
  logic [PW-1:0]     off_s, idx_s;

  // Merge lanes, coalesce into queued entries, allocate the rest at tail.
  always_comb begin
    bpc_d      = bpc_q;
    tgt_d      = tgt_q;
    deq_s      = (count_q != {CW{1'b0}});
    cap_s      = CW'(DEPTH) - count_q + CW'(deq_s);
    alloc_s    = {CW{1'b0}};
    drop_s     = 1'b0;
    lane_pc_s  = {ADDR_W{1'b0}};
    lane_tgt_s = {ADDR_W{1'b0}};
    survive_s  = 1'b0;
    hit_s      = 1'b0;
    off_s      = {PW{1'b0}};
    idx_s      = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      lane_pc_s  = bus.enq_branch_PC[i*ADDR_W +: ADDR_W];
      lane_tgt_s = bus.enq_target_PC[i*ADDR_W +: ADDR_W];
      survive_s  = bus.enq_valid[i];
      for (int j = 0; j < N; j++) begin
        if (j > i && bus.enq_valid[j] && bus.enq_branch_PC[j*ADDR_W +: ADDR_W] == lane_pc_s) begin
          survive_s = 1'b0;
        end else begin
          survive_s = survive_s;
        end
      end
      hit_s = 1'b0;
      // Offset 0 is the head leaving this cycle, so it never absorbs a newer target.
      for (int k = 0; k < DEPTH; k++) begin
        off_s = PW'(k) - head_q;
        if (survive_s && off_s != {PW{1'b0}} && CW'(off_s) < count_q && bpc_q[k] == lane_pc_s) begin
          tgt_d[k] = lane_tgt_s;
          hit_s    = 1'b1;
        end else begin
          hit_s = hit_s;
        end
      end
      if (survive_s && !hit_s) begin
        if (alloc_s < cap_s) begin
          idx_s        = tail_q + alloc_s[PW-1:0];
          bpc_d[idx_s] = lane_pc_s;
          tgt_d[idx_s] = lane_tgt_s;
          alloc_s      = alloc_s + CW'(1);
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        drop_s = drop_s;
      end
    end
    head_d  = head_q + PW'(deq_s);
    tail_d  = tail_q + alloc_s[PW-1:0];
    count_d = count_q + alloc_s - CW'(deq_s);
  end

  // Queue state registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        bpc_q[k] <= {ADDR_W{1'b0}};
        tgt_q[k] <= {ADDR_W{1'b0}};
      end
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      bpc_q      <= bpc_d;
      tgt_q      <= tgt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= drop_s;
    end
  end

  assign bus.free_slots          = CW'(DEPTH) - count_q;
  assign bus.overflow            = overflow_q;
  assign bus.resolving_valid     = deq_s;
  assign bus.resolving_branch_PC = deq_s ? bpc_q[head_q] : {ADDR_W{1'b0}};
  assign bus.resolving_target_PC = deq_s ? tgt_q[head_q] : {ADDR_W{1'b0}};
endmodule

// File: tb/tb_btb_update_queue.sv
// Directed scoreboard bench for btb_update_queue: expected drains are queued
// at issue time and checked by an independent monitor on the falling edge.
module tb_btb_update_queue;
  localparam int N      = 3;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  btb_update_queue_if #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  btb_update_queue #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented head must match the oldest expected update.
  always @(negedge clock) begin
    logic [63:0] e;
    if (reset === 1'b0 && bus.resolving_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_entry: got pc=%0h tgt=%0h expected nothing",
                 bus.resolving_branch_PC, bus.resolving_target_PC);
      end else begin
        e = sb.pop_front();
        if ({bus.resolving_branch_PC, bus.resolving_target_PC} !== e) begin
          fails++;
          $display("FAIL drain_entry: got pc=%0h tgt=%0h expected pc=%0h tgt=%0h",
                   bus.resolving_branch_PC, bus.resolving_target_PC, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt);
    sb.push_back({pc, tgt});
  endtask

  task automatic enq(input logic [2:0] v, input logic [95:0] pcs, input logic [95:0] tgts);
    bus.enq_valid     = v;
    bus.enq_branch_PC = pcs;
    bus.enq_target_PC = tgts;
    @(posedge clock);
    #1;
    bus.enq_valid = 3'b000;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.resolving_valid !== 1'b0) && n < 50) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk({name, "_drain_timeout"}, 32'(n < 50), 32'd1);
    chk({name, "_free_after"}, 32'(bus.free_slots), 32'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] p, t;
    int k;
    reset             = 1'b1;
    bus.enq_valid     = 3'b000;
    bus.enq_branch_PC = 96'h0;
    bus.enq_target_PC = 96'h0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // 1: idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("idle_valid", 32'(bus.resolving_valid), 32'd0);
      chk("idle_pc", bus.resolving_branch_PC, 32'h0);
      chk("idle_tgt", bus.resolving_target_PC, 32'h0);
      chk("idle_free", 32'(bus.free_slots), 32'd8);
      chk("idle_ovf", 32'(bus.overflow), 32'd0);
    end

    // 2: single update, no same-cycle bypass, one-cycle presence
    push(32'h100, 32'h200);
    bus.enq_valid     = 3'b001;
    bus.enq_branch_PC = {32'h0, 32'h0, 32'h100};
    bus.enq_target_PC = {32'h0, 32'h0, 32'h200};
    #1 chk("no_bypass", 32'(bus.resolving_valid), 32'd0);
    @(posedge clock);
    #1 bus.enq_valid = 3'b000;
    chk("single_free", 32'(bus.free_slots), 32'd7);
    @(posedge clock);
    #1 chk("single_gone", 32'(bus.resolving_valid), 32'd0);
    wait_drain("single");

    // 3: three-lane burst in order
    push(32'h100, 32'h200); push(32'h104, 32'h300); push(32'h108, 32'h400);
    enq(3'b111, {32'h108, 32'h104, 32'h100}, {32'h400, 32'h300, 32'h200});
    chk("burst_free", 32'(bus.free_slots), 32'd5);
    wait_drain("burst");

    // 4a: coalesce into a queued non-head entry
    push(32'h100, 32'h200); push(32'h110, 32'h600);
    enq(3'b011, {32'h0, 32'h110, 32'h100}, {32'h0, 32'h500, 32'h200});
    enq(3'b001, {32'h0, 32'h0, 32'h110}, {32'h0, 32'h0, 32'h600});
    chk("coalesce_free", 32'(bus.free_slots), 32'd7);
    wait_drain("coalesce");

    // 4b: same-cycle duplicate lanes, youngest wins
    push(32'h120, 32'h800);
    enq(3'b011, {32'h0, 32'h120, 32'h120}, {32'h0, 32'h800, 32'h700});
    chk("merge_free", 32'(bus.free_slots), 32'd7);
    wait_drain("merge");

    // 4c: match only against the dequeuing head allocates a new entry
    push(32'h130, 32'h1); push(32'h130, 32'h2);
    enq(3'b001, {32'h0, 32'h0, 32'h130}, {32'h0, 32'h0, 32'h1});
    enq(3'b001, {32'h0, 32'h0, 32'h130}, {32'h0, 32'h0, 32'h2});
    chk("headmatch_free", 32'(bus.free_slots), 32'd7);
    wait_drain("headmatch");

    // 4d: non-adjacent duplicates; survivors keep lane order
    push(32'h144, 32'h2); push(32'h140, 32'h3);
    enq(3'b111, {32'h140, 32'h144, 32'h140}, {32'h3, 32'h2, 32'h1});
    chk("merge2_free", 32'(bus.free_slots), 32'd6);
    wait_drain("merge2");

    // 5: fill to full, then overflow with capacity one; pointers wrap
    k = 0;
    for (int e = 0; e < 4; e++) begin
      p = 96'h0;
      t = 96'h0;
      for (int l = 0; l < ((e < 3) ? 3 : 2); l++) begin
        p[l*32 +: 32] = 32'h1000 + 32'(4 * k);
        t[l*32 +: 32] = 32'h2000 + 32'(k);
        push(p[l*32 +: 32], t[l*32 +: 32]);
        k++;
      end
      enq((e < 3) ? 3'b111 : 3'b011, p, t);
    end
    chk("full_free", 32'(bus.free_slots), 32'd0);
    chk("full_ovf", 32'(bus.overflow), 32'd0);
    push(32'h3000, 32'h4000);
    enq(3'b111, {32'h3008, 32'h3004, 32'h3000}, {32'h4008, 32'h4004, 32'h4000});
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_free", 32'(bus.free_slots), 32'd0);
    @(posedge clock);
    #1 chk("ovf_clear", 32'(bus.overflow), 32'd0);
    chk("ovf_free2", 32'(bus.free_slots), 32'd1);
    wait_drain("wrap");

    // 6: asynchronous reset with five entries queued
    for (int l = 0; l < 6; l++) push(32'h500 + 32'(4 * l), 32'h900 + 32'(l));
    enq(3'b111, {32'h508, 32'h504, 32'h500}, {32'h902, 32'h901, 32'h900});
    enq(3'b111, {32'h514, 32'h510, 32'h50c}, {32'h905, 32'h904, 32'h903});
    chk("pre_reset_free", 32'(bus.free_slots), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.resolving_valid), 32'd0);
    chk("rst_free", 32'(bus.free_slots), 32'd8);
    chk("rst_pc", bus.resolving_branch_PC, 32'h0);
    sb.delete();
    @(posedge clock);
    #1 chk("rst_hold_valid", 32'(bus.resolving_valid), 32'd0);
    reset = 1'b0;
    push(32'h600, 32'h700);
    enq(3'b001, {32'h0, 32'h0, 32'h600}, {32'h0, 32'h0, 32'h700});
    wait_drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
- Buffers resolved-branch BTB updates coming from the branch stack / complete stage. Up to N resolutions can arrive per cycle.
- Drains them one per cycle into the BTB write port (resolving_valid / resolving_branch_PC / resolving_target_PC).
- Coalesces updates to the same branch PC so that stale targets are never written.
- Sits directly upstream of the BTB. BTB contents are hints only, so overflow drops updates rather than stalling the pipeline.

Parameters:
- N, 3, resolutions accepted per cycle (matches `N).
- DEPTH, 8, queue entries; must be a power of 2 and >= N.
- ADDR_W, 32, PC width (ADDR).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enq_valid  in  N  lane i carries a resolved taken branch; lane 0 is oldest in program order.
- enq_branch_PC  in  N*ADDR_W  branch PC per lane.
- enq_target_PC  in  N*ADDR_W  resolved target per lane.
- free_slots  out  $clog2(DEPTH+1)  DEPTH minus registered count; advisory to upstream.
- overflow  out  1  registered pulse: one or more lanes were dropped in the previous cycle.
- resolving_valid  out  1  head entry valid (count != 0).
- resolving_branch_PC  out  ADDR_W  head branch PC; 0 when empty.
- resolving_target_PC  out  ADDR_W  head target; 0 when empty.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries {branch_PC, target_PC}.
  - head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- Reset (async):
  - head=tail=count=0, entries cleared, overflow=0.
  - Therefore resolving_valid=0, both PCs=0, free_slots=DEPTH.
  - Reset asserted mid-operation discards all queued updates immediately. No partial write reaches the BTB after reset rises.
- Dequeue:
  - The BTB always accepts, so when count!=0 the head entry is presented combinationally from registers and retired at that clock edge (head++).
  - One entry per cycle, exactly.
- Enqueue latency: an update accepted at edge t is presented no earlier than the cycle after t. There is no same-cycle bypass from enq to the resolving_* outputs.
- Intra-cycle merge:
  - Among valid lanes with equal branch_PC, only the highest-index (youngest) lane survives, using its target.
  - Lower duplicate lanes are discarded silently and do not count as overflow.
- Coalesce with queue:
  - A surviving lane whose branch_PC matches a queued entry other than the head being dequeued this cycle overwrites that entry's target_PC in place. No new slot is allocated.
  - A match only against the dequeuing head allocates a new entry, so the newer target follows the older one.
  - Queue entries are unique by branch_PC, so at most one entry can match.
- Allocation:
  - Remaining surviving lanes are written at tail, tail+1, ... in lane order (wrap-around permitted).
  - capacity = DEPTH - count + (count!=0 ? 1 : 0).
  - Lanes beyond capacity are dropped, highest lanes first.
- Overflow: if any lane is dropped at edge t, overflow=1 during cycle t+1, otherwise 0.
- Count update: next count = count + allocations - dequeue.
  - Never exceeds DEPTH.
  - Never underflows.
- Simultaneous events:
  - Full queue plus a dequeue plus an enqueue: exactly 1 new allocation is allowed.
  - Empty queue plus an enqueue: no dequeue this cycle.
- free_slots depends only on registered count. Upstream may treat it as a conservative estimate.

Test Plan:
1. Reset then idle: resolving_valid=0, PCs=0, free_slots=8, overflow=0 for 5 cycles.
2. Single update at cycle 1: lane0 PC=0x100, target=0x200.
   - Cycle 2: resolving_valid=1, PC=0x100, target=0x200.
   - Cycle 3: resolving_valid=0.
3. Three-lane burst in one cycle {0x100→0x200, 0x104→0x300, 0x108→0x400}: presented in that order on 3 consecutive cycles, free_slots returns to 8 afterwards.
4. Coalescing:
   - Queue holds 0x100→0x200 (head) and 0x110→0x500; enqueue 0x110→0x600. 0x110 is presented once, with target 0x600.
   - Same-cycle lanes 0x120→0x700 and 0x120→0x800: one entry, target 0x800.
5. Overflow and wrap:
   - Fill 8 distinct PCs, then enqueue 3 new distinct PCs in one cycle. Lane0 is accepted, lanes 1–2 are dropped.
   - overflow=1 on the next cycle only.
   - Draining yields 8 entries in FIFO order with the pointers wrapping past index 7.
6. Async reset mid-drain:
   - Assert reset between clock edges with count=5. resolving_valid=0 and free_slots=8 immediately.
   - After deassert, a new update drains normally.
